// File: rtl/opm_serial_dac_rx.sv
// opm_serial_dac_rx: receiver for the OPM serial DAC stream (SO data + SH strobes).
// A shared shift register collects floating-point frames; each channel latches
// the frame on its SH falling edge and converts it to signed linear PCM.
// Optional mixer: define OPM_DAC_MIX_EN to build the saturated channel sum on o_MIX;
// without it o_MIX is tied to 0 and no adder exists.

// Per-channel lane: SH edge detect, frame latch, float-to-linear decode.
module opm_serial_dac_rx_ch #(
  parameter int MANT_W = 10,
  parameter int EXP_W  = 3,
  parameter int OUT_W  = 16
) (
  input  logic                    i_EMUCLK,
  input  logic                    i_RST,
  input  logic                    i_phi1_PCEN,
  input  logic                    i_SH,
  input  logic [MANT_W+EXP_W-1:0] sr_frame,
  output logic [OUT_W-1:0]        sample,
  output logic                    valid,
  output logic                    err
);
  localparam int FRAME_W = MANT_W + EXP_W;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  logic               sh_z, sh_zz, ld;
  logic [FRAME_W-1:0] frame;
  // [0] = frame pending decode, [1] = output valid strobe
  logic [1:0]         vld_pipe;
  logic [EXP_W-1:0]   e;
  logic               s;
  logic [MANT_W-2:0]  m, m_n;
  logic [OUT_W-1:0]   mag, shifted, dec;

  // Falling edge of SH as seen through two phi1 samples; only meaningful on PCEN.
  assign ld    = i_phi1_PCEN & sh_zz & ~sh_z;
  assign e     = frame[FRAME_W-1 -: EXP_W];
  assign s     = frame[MANT_W-1];
  assign m     = frame[MANT_W-2:0];
  assign valid = vld_pipe[1];

  // SH sampling on phi1; sh_zz resetting low blocks a spurious edge after reset.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      sh_z  <= 1'b0;
      sh_zz <= 1'b0;
    end else if (i_phi1_PCEN) begin
      sh_z  <= i_SH;
      sh_zz <= sh_z;
    end
  end

  // Frame capture from the pre-shift SR value, plus the valid pipeline.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      frame    <= '0;
      vld_pipe <= '0;
    end else begin
      if (ld) frame <= sr_frame;
      vld_pipe <= {vld_pipe[0], ld};
    end
  end

  // Decode: sign=1 is positive magnitude m, sign=0 is negative with inverted m.
  always_comb begin
    m_n     = ~m;
    mag     = s ? OUT_W'(m) : OUT_W'(m_n);
    shifted = mag << (e - EXP_ONE);
    dec     = '0;
    if (e != '0) dec = s ? shifted : -shifted;
  end

  // Output register: sample holds between frames, exponent-0 error is sticky.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      sample <= '0;
      err    <= 1'b0;
    end else if (vld_pipe[0]) begin
      sample <= dec;
      if (e == '0) err <= 1'b1;
    end
  end
endmodule

// Top: shared shift register, channel lanes, optional saturating mixer.
module opm_serial_dac_rx #(
  parameter int NUM_CH = 2,
  parameter int MANT_W = 10,
  parameter int EXP_W  = 3,
  parameter int OUT_W  = 16
) (
  input  logic                    i_EMUCLK,
  input  logic                    i_RST,
  input  logic                    i_phi1_PCEN,
  input  logic                    i_SO,
  input  logic [NUM_CH-1:0]       i_SH,
  output logic [NUM_CH*OUT_W-1:0] o_SAMPLE,
  output logic [NUM_CH-1:0]       o_VALID,
  output logic [NUM_CH-1:0]       o_ERR,
  output logic [OUT_W-1:0]        o_MIX
);
  localparam int FRAME_W = MANT_W + EXP_W;

  // Largest decoded magnitude is a full mantissa shifted by 2**EXP_W-2.
  if (OUT_W < MANT_W + 2**EXP_W - 2) begin : g_bad_cfg
    $error("opm_serial_dac_rx: OUT_W too narrow for MANT_W/EXP_W");
  end

  logic [FRAME_W:0]                sr;
  logic [NUM_CH-1:0][OUT_W-1:0]    sample_q;

  // Serial data enters at the MSB; one extra bit sits above the frame window.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST)            sr <= '0;
    else if (i_phi1_PCEN) sr <= {i_SO, sr[FRAME_W:1]};
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    opm_serial_dac_rx_ch #(
      .MANT_W (MANT_W),
      .EXP_W  (EXP_W),
      .OUT_W  (OUT_W)
    ) u_ch (
      .i_EMUCLK    (i_EMUCLK),
      .i_RST       (i_RST),
      .i_phi1_PCEN (i_phi1_PCEN),
      .i_SH        (i_SH[k]),
      .sr_frame    (sr[FRAME_W-1:0]),
      .sample      (sample_q[k]),
      .valid       (o_VALID[k]),
      .err         (o_ERR[k])
    );
  end

  // Packed layout places channel k at [k*OUT_W +: OUT_W].
  assign o_SAMPLE = sample_q;

`ifdef OPM_DAC_MIX_EN
  localparam int SUM_W = OUT_W + $clog2(NUM_CH);
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(2**(OUT_W-1) - 1);
  localparam logic signed [SUM_W-1:0] MIN_S = ~MAX_S;

  logic signed [SUM_W-1:0] sum;
  logic        [OUT_W-1:0] mix_sat;

  // Widened sum of the currently held samples, clamped to the OUT_W range.
  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_CH; k++) sum = sum + SUM_W'($signed(sample_q[k]));
    if (sum > MAX_S)      mix_sat = MAX_S[OUT_W-1:0];
    else if (sum < MIN_S) mix_sat = MIN_S[OUT_W-1:0];
    else                  mix_sat = sum[OUT_W-1:0];
  end

  // Mix refreshes the cycle after any channel publishes a new sample.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST)          o_MIX <= '0;
    else if (|o_VALID)  o_MIX <= mix_sat;
  end
`else
  assign o_MIX = '0;
`endif
endmodule

// File: doc/opm_serial_dac_rx.md
Name: opm_serial_dac_rx

Overview:
Synthesizable, parametrised receiver for the OPM serial DAC stream (SO / SH strobes). It deserialises floating-point sample frames, detects per-channel SH falling edges, and converts mantissa/exponent frames to signed linear PCM. It sits between the IKAOPM core outputs (o_SO, o_SH1/o_SH2, phi1 enable) and the audio output or mixing path. It replaces the behavioural two-channel YM3012 bench model and adds N channels, configurable formats, error flags and a valid strobe.

Parameters:
NUM_CH, 2, number of SH strobes / output channels (ch0 = SH1/right, ch1 = SH2/left)
MANT_W, 10, mantissa width including sign bit (sign = MSB)
EXP_W, 3, exponent width
OUT_W, 16, signed output width; must be >= MANT_W + 2**EXP_W - 2 (checked with a generate-time error)

Ports:
i_EMUCLK  in  1  system clock; all logic on rising edge
i_RST  in  1  asynchronous active-high reset
i_phi1_PCEN  in  1  one-cycle enable marking each phi1 rising edge
i_SO  in  1  serial data
i_SH  in  NUM_CH  sample-hold strobes, one per channel
o_SAMPLE  out  NUM_CH*OUT_W  signed PCM per channel; ch k at [k*OUT_W +: OUT_W]
o_VALID  out  NUM_CH  one-EMUCLK pulse per channel when its o_SAMPLE updates
o_ERR  out  NUM_CH  sticky per-channel flag: exponent-0 frame received
o_MIX  out  OUT_W  saturated channel sum (optional feature)

Behaviour:
- Define FRAME_W = MANT_W + EXP_W. Frame layout: [FRAME_W-1 -: EXP_W] = exponent e; [MANT_W-1] = sign s; [MANT_W-2:0] = magnitude m.
- Shift register SR is FRAME_W+1 bits wide and shared by all channels. On i_phi1_PCEN: SR <= {i_SO, SR[FRAME_W:1]} (data enters at the MSB and shifts right). When i_phi1_PCEN is low, SR holds.
- Per channel on i_phi1_PCEN: sh_z[k] <= i_SH[k]; sh_zz[k] <= sh_z[k]. Load condition ld[k] = sh_zz[k] & ~sh_z[k] (SH falling edge, seen with a two-phi1 delay). ld is evaluated only on PCEN cycles.
- On a PCEN cycle with ld[k], latch frame[k] <= SR[FRAME_W-1:0], using the SR value before that cycle's shift. Set pend[k].
- Decode stage, on the cycle after the latch: the pend[k] register drives the o_SAMPLE[k] update, o_VALID[k] = 1 for exactly one cycle, and pend[k] is cleared. Latency is one EMUCLK cycle from latch to output.
- Decode rules:
  - e >= 1, s = 1: +(zero-extended m) << (e-1).
  - e >= 1, s = 0: -((~m zero-extended) << (e-1)).
  - e = 0: output 0 and set o_ERR[k]. o_VALID still pulses.
- All arithmetic is done at OUT_W width; no overflow is possible given the parameter check.
- Channels are independent. Simultaneous ld on several channels latches the same SR value into each, and all of their o_VALID bits pulse together.
- o_SAMPLE holds its last value between frames.
- o_ERR stays set until reset.
- Reset (async, any time, including mid-frame): SR, sh_z, sh_zz, frame, pend, o_SAMPLE, o_VALID, o_ERR and o_MIX all go to 0.
  - Because sh_zz resets to 0, no spurious ld can occur on the first PCEN after reset.
  - A partially shifted frame is discarded.
  - After reset release, the first valid output needs a full SH high-to-low cycle.
- An SH pulse that goes high and low between two PCENs is not seen.

Optional Feature:
Macro OPM_DAC_MIX_EN.
- Defined: o_MIX is registered and updated on the cycle after any o_VALID bit. It equals the sum of all current o_SAMPLE channels, computed at OUT_W + clog2(NUM_CH) width and saturated to the OUT_W signed range. It resets to 0.
- Undefined: no adder is built and o_MIX is tied to 0.

Test Plan:
- Reset check: assert i_RST mid-frame, then toggle SH with no frame. Required: all outputs 0, no o_VALID pulse until a full SH high-to-low cycle after release.
- Positive frame on ch0: serial frame e=3, s=1, m=0x155, then SH1 falling edge. Required: o_SAMPLE[0] = 1364 (0x0554); o_VALID[0] pulses one cycle, exactly 1 EMUCLK after the latch PCEN.
- Negative full scale on ch1: e=7, s=0, m=0x000. Required: o_SAMPLE[1] = -32704 (0x8040); ch0 value unchanged.
- Small value: e=1, s=1, m=0x1FF. Required: 511.
- Error frame: e=0 on ch0. Required: o_SAMPLE[0] = 0, o_ERR[0] = 1 and staying 1 after a following good frame; o_ERR[1] = 0.
- Mix saturation (OPM_DAC_MIX_EN defined): both channels receive e=7, s=1, m=0x1FF (32704 each). Required: o_MIX = 32767. With the macro undefined, o_MIX = 0.
